// File: rtl/zap_fetch_wb_master_pkg.sv
// rtl/zap_fetch_wb_master_pkg.sv - shared types, constants and FIFO word packing for the fetch master
package zap_fetch_pkg;

   localparam int PC_W      = 32;
   localparam int IW        = 32;
   localparam int ABORT_BIT = PC_W + IW;
   localparam int FW        = ABORT_BIT + 1;

   localparam logic [2:0]      CTI_CLASSIC = 3'b000;
   localparam logic [PC_W-1:0] PC_STEP     = PC_W'(4);
   localparam logic [PC_W-1:0] WORD_MASK   = {{(PC_W-2){1'b1}}, 2'b00};

   typedef enum logic [1:0] {IDLE, ACTIVE, KILL, ABORT} fetch_state_t;

   // The decode side unpacks with the same field order.
   function automatic logic [FW-1:0] fetch_pack(input logic            abort,
                                                input logic [PC_W-1:0] pc,
                                                input logic [IW-1:0]   instr);
      return {abort, pc, instr};
   endfunction

endpackage

// File: rtl/zap_fetch_wb_master_if.sv
// rtl/zap_fetch_wb_master_if.sv - Wishbone classic read bus between fetch master and memory
interface zap_fetch_wb_master_if;
   import zap_fetch_pkg::*;

   logic            wb_cyc;
   logic            wb_stb;
   logic [PC_W-1:0] wb_adr;
   logic            wb_we;
   logic [IW/8-1:0] wb_sel;
   logic [2:0]      wb_cti;
   logic            wb_ack;
   logic            wb_err;
   logic [IW-1:0]   wb_dat;

   modport master (
      output wb_cyc, wb_stb, wb_adr, wb_we, wb_sel, wb_cti,
      input  wb_ack, wb_err, wb_dat
   );

   modport slave (
      input  wb_cyc, wb_stb, wb_adr, wb_we, wb_sel, wb_cti,
      output wb_ack, wb_err, wb_dat
   );

endinterface

// File: rtl/zap_fetch_wb_master.sv
// rtl/zap_fetch_wb_master.sv - sequential instruction fetch over Wishbone classic, one read outstanding
module zap_fetch_wb_master
   import zap_fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_redirect,
   input  logic [PC_W-1:0]       i_redirect_pc,
   input  logic                  i_halt,
   input  logic                  i_fifo_full_n,
   input  logic                  i_fifo_full_n_nxt,
   output logic                  o_fifo_valid,
   output logic [FW-1:0]         o_fifo_data,
   zap_fetch_wb_master_if.master wb
);

   localparam logic [PC_W-1:0] START_PC = RESET_PC & WORD_MASK;

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] adr_q, adr_d;
   logic            stb_q, stb_d;
   logic            valid_q, valid_d;
   logic [FW-1:0]   data_q, data_d;
   logic            term;
   logic [PC_W-1:0] redirect_tgt;

   assign term         = wb.wb_ack | wb.wb_err;
   assign redirect_tgt = i_redirect_pc & WORD_MASK;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      adr_d   = adr_q;
      stb_d   = stb_q;
      valid_d = 1'b0;
      data_d  = data_q;

      if (i_redirect) begin
         pc_d = redirect_tgt;
      end

      case (state_q)
         IDLE: begin
            // A push still on the FIFO port this cycle may take the last slot.
            if (!i_redirect && !i_halt && i_fifo_full_n &&
                (!valid_q || i_fifo_full_n_nxt)) begin
               stb_d   = 1'b1;
               adr_d   = pc_q;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (i_redirect) begin
               if (term) begin
                  stb_d   = 1'b0;
                  state_d = IDLE;
               end else begin
                  state_d = KILL;
               end
            end else if (wb.wb_ack) begin
               valid_d = 1'b1;
               data_d  = fetch_pack(1'b0, adr_q, wb.wb_dat);
               pc_d    = pc_q + PC_STEP;
               if (i_fifo_full_n_nxt && !i_halt) begin
                  adr_d = pc_q + PC_STEP;
               end else begin
                  stb_d   = 1'b0;
                  state_d = IDLE;
               end
            end else if (wb.wb_err) begin
               valid_d = 1'b1;
               data_d  = fetch_pack(1'b1, adr_q, '0);
               stb_d   = 1'b0;
               state_d = ABORT;
            end
         end
         KILL: begin
            if (term) begin
               stb_d   = 1'b0;
               state_d = IDLE;
            end
         end
         ABORT: begin
            if (i_redirect) begin
               state_d = IDLE;
            end
         end
         default: begin
            stb_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= IDLE;
         pc_q    <= START_PC;
         adr_q   <= '0;
         stb_q   <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         adr_q   <= adr_d;
         stb_q   <= stb_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign wb.wb_cyc    = stb_q;
   assign wb.wb_stb    = stb_q;
   assign wb.wb_adr    = adr_q;
   assign wb.wb_we     = 1'b0;
   assign wb.wb_sel    = '1;
   assign wb.wb_cti    = CTI_CLASSIC;
   assign o_fifo_valid = valid_q;
   assign o_fifo_data  = data_q;

endmodule

// File: tb/tb_zap_fetch_wb_master.sv
// tb/tb_zap_fetch_wb_master.sv - self-checking bench for zap_fetch_wb_master
module tb_zap_fetch_wb_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rst2_n = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        halt = 1'b0;
   logic        full_n = 1'b1;
   logic        full_n_nxt = 1'b1;
   logic        fifo_valid, fifo_valid2;
   logic [64:0] fifo_data, fifo_data2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   zap_fetch_wb_master_if wb ();
   zap_fetch_wb_master_if wb2 ();

   zap_fetch_wb_master #(.RESET_PC(32'h0000_0000)) u_dut (
      .i_clk             (clk),
      .i_reset           (rst_n),
      .i_redirect        (redirect),
      .i_redirect_pc     (redirect_pc),
      .i_halt            (halt),
      .i_fifo_full_n     (full_n),
      .i_fifo_full_n_nxt (full_n_nxt),
      .o_fifo_valid      (fifo_valid),
      .o_fifo_data       (fifo_data),
      .wb                (wb)
   );

   // Second instance exercises a non-zero reset PC and address wrap.
   zap_fetch_wb_master #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
      .i_clk             (clk),
      .i_reset           (rst2_n),
      .i_redirect        (1'b0),
      .i_redirect_pc     (32'h0),
      .i_halt            (1'b0),
      .i_fifo_full_n     (1'b1),
      .i_fifo_full_n_nxt (1'b1),
      .o_fifo_valid      (fifo_valid2),
      .o_fifo_data       (fifo_data2),
      .wb                (wb2)
   );

   assign wb2.wb_ack = wb2.wb_stb;
   assign wb2.wb_err = 1'b0;
   assign wb2.wb_dat = ~wb2.wb_adr;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return 32'hD000_0000 ^ a;
   endfunction

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Scoreboard of FIFO words every test expects, in order.
   logic [64:0] exp_q[$];
   int          wait_states = 0;
   logic [31:0] err_adr = 32'hFFFF_FFFF;
   int          wcnt = 0;
   logic        prev_stb = 1'b0;
   logic        prev_term = 1'b0;
   logic [31:0] prev_adr = 32'h0;

   task automatic exp_push(input logic ab, input logic [31:0] pc, input logic [31:0] ins);
      exp_q.push_back({ab, pc, ins});
   endtask

   // Compare process and Wishbone slave model, both on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         wb.wb_ack = 1'b0;
         wb.wb_err = 1'b0;
         wb.wb_dat = 32'h0;
         wcnt      = 0;
         prev_stb  = 1'b0;
         prev_term = 1'b0;
      end else begin
         chk("wb_const", {53'h0, wb.wb_cyc, wb.wb_we, wb.wb_sel, wb.wb_cti, wb.wb_adr[1:0]},
             {53'h0, wb.wb_stb, 1'b0, 4'hF, 3'b000, 2'b00});
         if (prev_stb && !prev_term)
            chk("wb_hold", {32'h0, wb.wb_stb, wb.wb_adr}, {32'h0, 1'b1, prev_adr});
         if (fifo_valid) begin
            chk("push_space", {64'h0, full_n}, 65'h1);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL push_unexpected actual=%h required=none", fifo_data);
            end else begin
               chk("push_data", fifo_data, exp_q.pop_front());
            end
         end
         wb.wb_ack = 1'b0;
         wb.wb_err = 1'b0;
         wb.wb_dat = 32'h0;
         if (!wb.wb_stb) begin
            wcnt = 0;
         end else if (wcnt >= wait_states) begin
            if (wb.wb_adr == err_adr) wb.wb_err = 1'b1;
            else begin
               wb.wb_ack = 1'b1;
               wb.wb_dat = mem(wb.wb_adr);
            end
            wcnt = 0;
         end else begin
            wcnt++;
         end
         prev_stb  = wb.wb_stb;
         prev_adr  = wb.wb_adr;
         prev_term = wb.wb_ack | wb.wb_err;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_adr(input logic [31:0] a, input string name);
      int n = 0;
      while (!(wb.wb_stb && wb.wb_adr == a) && n < 40) begin
         tick();
         n++;
      end
      chk(name, {32'h0, wb.wb_stb, wb.wb_adr}, {32'h0, 1'b1, a});
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      tick();
      chk(name, 65'(exp_q.size()), 65'h0);
      chk({name, "_idle"}, {64'h0, wb.wb_stb}, 65'h0);
   endtask

   task automatic restart_at(input logic [31:0] a);
      redirect_pc = a;
      redirect    = 1'b1;
      tick();
      redirect    = 1'b0;
      halt        = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      wb.wb_ack = 1'b0;
      wb.wb_err = 1'b0;
      wb.wb_dat = 32'h0;
      repeat (2) tick();
      chk("reset_state", {wb.wb_stb, wb.wb_adr, fifo_valid, 31'h0}, 65'h0);
      chk("reset_data", fifo_data, 65'h0);
      chk("reset2_state", {32'h0, wb2.wb_cyc, wb2.wb_adr}, 65'h0);

      // 1: zero-wait streaming from reset.
      exp_push(1'b0, 32'h0, mem(32'h0));
      exp_push(1'b0, 32'h4, mem(32'h4));
      exp_push(1'b0, 32'h8, mem(32'h8));
      exp_push(1'b0, 32'hC, mem(32'hC));
      rst_n = 1'b1;
      tick();
      chk("t1_latency", {32'h0, wb.wb_stb, wb.wb_adr}, {32'h0, 1'b1, 32'h0});
      tick();
      chk("t1_adr4", {32'h0, wb.wb_stb, wb.wb_adr}, {32'h0, 1'b1, 32'h4});
      chk("t1_first_push", {fifo_valid, fifo_data}, {1'b1, 1'b0, 32'h0, 32'hD000_0000});
      tick();
      chk("t1_adr8", {32'h0, wb.wb_stb, wb.wb_adr}, {32'h0, 1'b1, 32'h8});
      tick();
      chk("t1_adrC", {32'h0, wb.wb_stb, wb.wb_adr}, {32'h0, 1'b1, 32'hC});
      halt = 1'b1;
      drain("t1_drain");

      // 2: FIFO nearly full at the ack of adr 8.
      exp_push(1'b0, 32'h0, mem(32'h0));
      exp_push(1'b0, 32'h4, mem(32'h4));
      exp_push(1'b0, 32'h8, mem(32'h8));
      exp_push(1'b0, 32'hC, mem(32'hC));
      restart_at(32'h0);
      wait_adr(32'h8, "t2_adr8");
      full_n_nxt = 1'b0;
      tick();
      chk("t2_stop", {63'h0, wb.wb_stb, fifo_valid}, {63'h0, 1'b0, 1'b1});
      tick();
      full_n = 1'b0;
      repeat (3) begin
         tick();
         chk("t2_no_req", {64'h0, wb.wb_stb}, 65'h0);
      end
      full_n     = 1'b1;
      full_n_nxt = 1'b1;
      tick();
      chk("t2_resume", {32'h0, wb.wb_stb, wb.wb_adr}, {32'h0, 1'b1, 32'hC});
      halt = 1'b1;
      drain("t2_drain");

      // 3: redirect while adr 4 is stalled on the bus.
      wait_states = 3;
      exp_push(1'b0, 32'h0,   mem(32'h0));
      exp_push(1'b0, 32'h100, mem(32'h100));
      restart_at(32'h0);
      wait_adr(32'h4, "t3_adr4");
      redirect_pc = 32'h100;
      redirect    = 1'b1;
      tick();
      redirect = 1'b0;
      chk("t3_hold", {32'h0, wb.wb_stb, wb.wb_adr}, {32'h0, 1'b1, 32'h4});
      wait_adr(32'h100, "t3_adr100");
      halt = 1'b1;
      drain("t3_drain");
      wait_states = 0;

      // 4: redirect in the same cycle as the ack of adr 8.
      exp_push(1'b0, 32'h0,  mem(32'h0));
      exp_push(1'b0, 32'h4,  mem(32'h4));
      exp_push(1'b0, 32'h40, mem(32'h40));
      restart_at(32'h0);
      wait_adr(32'h8, "t4_adr8");
      redirect_pc = 32'h40;
      redirect    = 1'b1;
      tick();
      redirect = 1'b0;
      chk("t4_drop", {63'h0, wb.wb_stb, fifo_valid}, 65'h0);
      tick();
      chk("t4_target", {32'h0, wb.wb_stb, wb.wb_adr}, {32'h0, 1'b1, 32'h40});
      halt = 1'b1;
      drain("t4_drain");

      // 5: bus error becomes a prefetch abort; redirect low bits ignored.
      err_adr = 32'h10;
      exp_push(1'b0, 32'h8,  mem(32'h8));
      exp_push(1'b0, 32'hC,  mem(32'hC));
      exp_push(1'b1, 32'h10, 32'h0);
      restart_at(32'h8);
      wait_adr(32'h10, "t5_adr10");
      tick();
      chk("t5_err_push", {fifo_valid, fifo_data}, {1'b1, 1'b1, 32'h10, 32'h0});
      chk("t5_err_stb", {64'h0, wb.wb_stb}, 65'h0);
      repeat (4) begin
         tick();
         chk("t5_abort_quiet", {64'h0, wb.wb_stb}, 65'h0);
      end
      err_adr = 32'hFFFF_FFFF;
      exp_push(1'b0, 32'h200, mem(32'h200));
      redirect_pc = 32'h203;
      redirect    = 1'b1;
      tick();
      redirect = 1'b0;
      chk("t5_redirect_idle", {64'h0, wb.wb_stb}, 65'h0);
      tick();
      chk("t5_resume", {32'h0, wb.wb_stb, wb.wb_adr}, {32'h0, 1'b1, 32'h200});
      halt = 1'b1;
      drain("t5_drain");

      // 6: non-zero reset PC wraps modulo 2^32, then async reset mid-access.
      rst2_n = 1'b1;
      tick();
      chk("t6_adr0", {32'h0, wb2.wb_stb, wb2.wb_adr}, {32'h0, 1'b1, 32'hFFFF_FFF8});
      tick();
      chk("t6_adr1", {32'h0, wb2.wb_stb, wb2.wb_adr}, {32'h0, 1'b1, 32'hFFFF_FFFC});
      chk("t6_push0", {fifo_valid2, fifo_data2}, {1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0000_0007});
      tick();
      chk("t6_wrap", {32'h0, wb2.wb_stb, wb2.wb_adr}, {32'h0, 1'b1, 32'h0000_0000});
      #2;
      rst2_n = 1'b0;
      #1;
      chk("t6_async_drop", {63'h0, wb2.wb_cyc, wb2.wb_stb}, 65'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
